vga_sync_gen: RTL

Generates 640x480@60 Hz VGA raster timing for the console video path and sits directly upstream of the pixel print stage. It divides the system clock into a pixel tick and runs horizontal and vertical counters. From them it drives `pixel_x`, `pixel_y`, `active_area`, `hsync` and `vsync`. It also flags frame boundaries so the print stage can detect end-of-screen and fetch the next frame's register and memory data.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/pixel_tick_gen.sv | 37 +++
 rtl/vga_sync_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing defaults, widths and FSM state type
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_CLK_DIV  = 2;

   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
   localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } vga_state_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - clk-to-pixel divider producing a registered last-clk tick
module pixel_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic active,
   output logic tick
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;
   logic [DW-1:0] div_nx;

   // next divider phase: held at 0 while cleared, wraps after the last clk of a pixel
   always_comb begin
      div_nx = div + 1'b1;
      if (clear || div == DIV_LAST) begin
         div_nx = '0;
      end
   end

   // tick marks the last clk of a pixel, so it is decoded from the next phase
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div  <= '0;
         tick <= 1'b0;
      end else begin
         div  <= div_nx;
         tick <= active && (div_nx == DIV_LAST);
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters, run/stop FSM and registered sync decode
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int CLK_DIV  = VGA_CLK_DIV
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           enable,
   output logic [X_W-1:0] pixel_x,
   output logic [Y_W-1:0] pixel_y,
   output logic           active_area,
   output logic           hsync,
   output logic           vsync,
   output logic           pixel_tick,
   output logic           frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] HS_BEG_X = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] HS_END_X = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] VS_BEG_Y = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] VS_END_Y = Y_W'(V_ACTIVE + V_FP + V_SYNC);

   vga_state_t     state;
   vga_state_t     state_nx;
   logic [X_W-1:0] h_nx;
   logic [Y_W-1:0] v_nx;
   logic           running;
   logic           run_nx;
   logic           adv;
   logic           h_end;
   logic           frame_end;

   assign running   = (state != ST_IDLE);
   assign adv       = running && pixel_tick;
   assign h_end     = (pixel_x == H_LAST);
   assign frame_end = adv && h_end && (pixel_y == V_LAST);

   // divider restarts from phase 0 on the first RUN clk; pixel_tick is its registered tick
   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (!running),
      .active  (run_nx),
      .tick    (pixel_tick)
   );

   // run/stop FSM: STOP finishes the frame unless enable comes back first
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_nx = ST_RUN;
            end
         end
         ST_RUN, ST_STOP: begin
            if (enable) begin
               state_nx = ST_RUN;
            end else if (frame_end) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_STOP;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      run_nx = (state_nx != ST_IDLE);
   end

   // next raster position; forced to the origin whenever the next state is IDLE
   always_comb begin
      h_nx = pixel_x;
      v_nx = pixel_y;
      if (!run_nx) begin
         h_nx = '0;
         v_nx = '0;
      end else if (adv) begin
         if (h_end) begin
            h_nx = '0;
            v_nx = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
         end else begin
            h_nx = pixel_x + 1'b1;
         end
      end
   end

   // outputs decoded from next-state values so they move together with the position
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         pixel_x     <= '0;
         pixel_y     <= '0;
         active_area <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         pixel_x     <= h_nx;
         pixel_y     <= v_nx;
         active_area <= run_nx && (h_nx < H_ACT_X) && (v_nx < V_ACT_Y);
         hsync       <= !(run_nx && (h_nx >= HS_BEG_X) && (h_nx < HS_END_X));
         vsync       <= !(run_nx && (v_nx >= VS_BEG_Y) && (v_nx < VS_END_Y));
         frame_start <= run_nx && (!running || frame_end);
      end
   end

endmodule
